ptw_axi_arbiter: RTL and testbench

- Shares the single page-table-walk AXI master read port between the instruction TLB and the data TLB.
- Each TLB issues one-cycle address pulses per walk level. This block latches the pulses, grants one outstanding PTE read at a time using round-robin priority, and routes the returned PTE back to the owner.
- A watchdog releases a stuck read and reports an access fault to the owner.

---
 rtl/ptw_axi_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ptw_axi_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_axi_arbiter.sv
// Shares the page-table-walk AXI read port between the ITLB and the DTLB.
// Requests wait in per-requester slots and are granted one at a time in round-robin order.
module ptw_axi_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] I_ADDR,
    output logic                  I_DATA_VALID,
    output logic                  I_ACCESS_FAULT,
    input  logic                  D_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] D_ADDR,
    output logic                  D_DATA_VALID,
    output logic                  D_ACCESS_FAULT,
    output logic [DATA_WIDTH-1:0] PTE_DATA,
    output logic                  M_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic                  M_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  OVERFLOW
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state;
    req_t                  owner;
    req_t                  rr_ptr;
    req_t                  winner;
    logic [CNT_WIDTH-1:0]  wd_cnt;

    logic                  i_pend;
    logic [ADDR_WIDTH-1:0] i_pend_addr;
    logic                  d_pend;
    logic [ADDR_WIDTH-1:0] d_pend_addr;

    logic                  m_addr_valid_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic                  i_fault_q;
    logic                  d_fault_q;
    logic                  overflow_q;

    logic                  in_wait;
    logic                  done;
    logic                  i_free;
    logic                  d_free;
    logic                  i_full;
    logic                  d_full;

    // A transaction ends on returned data or on the last allowed WAIT cycle.
    assign in_wait = (state == WAIT);
    assign done    = in_wait && (M_DATA_VALID || (wd_cnt == TIMEOUT_LAST));
    assign i_free  = done && (owner == REQ_I);
    assign d_free  = done && (owner == REQ_D);
    assign i_full  = i_pend && !i_free;
    assign d_full  = d_pend && !d_free;

    always_comb begin
        winner = REQ_I;
        if (i_pend && d_pend) begin
            winner = rr_ptr;
        end else if (d_pend) begin
            winner = REQ_D;
        end
    end

    assign I_DATA_VALID   = in_wait && M_DATA_VALID && (owner == REQ_I);
    assign D_DATA_VALID   = in_wait && M_DATA_VALID && (owner == REQ_D);
    assign PTE_DATA       = M_DATA;
    assign M_ADDR_VALID   = m_addr_valid_q;
    assign M_ADDR         = m_addr_q;
    assign I_ACCESS_FAULT = i_fault_q;
    assign D_ACCESS_FAULT = d_fault_q;
    assign OVERFLOW       = overflow_q;

    // Freeing a slot and accepting a new pulse in the same cycle leaves it loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            i_pend      <= 1'b0;
            i_pend_addr <= '0;
            d_pend      <= 1'b0;
            d_pend_addr <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (I_ADDR_VALID) begin
                if (!i_full) begin
                    i_pend      <= 1'b1;
                    i_pend_addr <= I_ADDR;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (i_free) begin
                i_pend <= 1'b0;
            end

            if (D_ADDR_VALID) begin
                if (!d_full) begin
                    d_pend      <= 1'b1;
                    d_pend_addr <= D_ADDR;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (d_free) begin
                d_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            owner          <= REQ_I;
            rr_ptr         <= REQ_I;
            wd_cnt         <= '0;
            m_addr_valid_q <= 1'b0;
            m_addr_q       <= '0;
            i_fault_q      <= 1'b0;
            d_fault_q      <= 1'b0;
        end else begin
            m_addr_valid_q <= 1'b0;
            i_fault_q      <= 1'b0;
            d_fault_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        m_addr_q       <= (winner == REQ_I) ? i_pend_addr : d_pend_addr;
                        m_addr_valid_q <= 1'b1;
                        owner          <= winner;
                        wd_cnt         <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // Returned data beats a coincident timeout.
                    if (M_DATA_VALID) begin
                        rr_ptr <= (owner == REQ_I) ? REQ_D : REQ_I;
                        state  <= IDLE;
                    end else if (wd_cnt == TIMEOUT_LAST) begin
                        i_fault_q <= (owner == REQ_I);
                        d_fault_q <= (owner == REQ_D);
                        rr_ptr    <= (owner == REQ_I) ? REQ_D : REQ_I;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Directed bench for ptw_axi_arbiter: a cycle-stamped request model checks every cycle,
// and hand-computed expectations pin grant latency, fairness, overflow, timeout and reset.
module tb_ptw_axi_arbiter;

    localparam int TO = 16;

    logic        CLK;
    logic        RST;
    logic        I_ADDR_VALID;
    logic [63:0] I_ADDR;
    logic        I_DATA_VALID;
    logic        I_ACCESS_FAULT;
    logic        D_ADDR_VALID;
    logic [63:0] D_ADDR;
    logic        D_DATA_VALID;
    logic        D_ACCESS_FAULT;
    logic [63:0] PTE_DATA;
    logic        M_ADDR_VALID;
    logic [63:0] M_ADDR;
    logic        M_DATA_VALID;
    logic [63:0] M_DATA;
    logic        OVERFLOW;

    int n_vec  = 0;
    int n_miss = 0;

    ptw_axi_arbiter #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (64),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (5)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .I_ADDR_VALID  (I_ADDR_VALID),
        .I_ADDR        (I_ADDR),
        .I_DATA_VALID  (I_DATA_VALID),
        .I_ACCESS_FAULT(I_ACCESS_FAULT),
        .D_ADDR_VALID  (D_ADDR_VALID),
        .D_ADDR        (D_ADDR),
        .D_DATA_VALID  (D_DATA_VALID),
        .D_ACCESS_FAULT(D_ACCESS_FAULT),
        .PTE_DATA      (PTE_DATA),
        .M_ADDR_VALID  (M_ADDR_VALID),
        .M_ADDR        (M_ADDR),
        .M_DATA_VALID  (M_DATA_VALID),
        .M_DATA        (M_DATA),
        .OVERFLOW      (OVERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending requests per requester, one busy transaction stamped with its issue cycle.
    int          cyc = 0;
    logic        m_ready = 1'b0;
    logic        pv[2];
    logic [63:0] pa[2];
    logic        busy;
    logic        own;
    logic        pref;
    int          issue_cyc;
    logic        e_mav;
    logic [63:0] e_maddr;
    logic        e_fault[2];
    logic        e_ovf;

    always @(posedge CLK) begin : model
        logic        req[2];
        logic [63:0] ra[2];
        logic        w;
        req[0] = I_ADDR_VALID;
        req[1] = D_ADDR_VALID;
        ra[0]  = I_ADDR;
        ra[1]  = D_ADDR;
        if (RST) begin
            m_ready    = 1'b1;
            pv[0]      = 1'b0;
            pv[1]      = 1'b0;
            pa[0]      = '0;
            pa[1]      = '0;
            busy       = 1'b0;
            own        = 1'b0;
            pref       = 1'b0;
            issue_cyc  = 0;
            e_mav      = 1'b0;
            e_maddr    = '0;
            e_fault[0] = 1'b0;
            e_fault[1] = 1'b0;
            e_ovf      = 1'b0;
        end else begin
            e_mav      = 1'b0;
            e_fault[0] = 1'b0;
            e_fault[1] = 1'b0;
            if (busy) begin
                if (M_DATA_VALID || (cyc - issue_cyc == TO - 1)) begin
                    if (!M_DATA_VALID) e_fault[own] = 1'b1;
                    pv[own] = 1'b0;
                    pref    = ~own;
                    busy    = 1'b0;
                end
            end else if (pv[0] || pv[1]) begin
                w         = (pv[0] && pv[1]) ? pref : pv[1];
                busy      = 1'b1;
                own       = w;
                issue_cyc = cyc + 1;
                e_mav     = 1'b1;
                e_maddr   = pa[w];
            end
            for (int x = 0; x < 2; x++) begin
                if (req[x]) begin
                    if (!pv[x]) begin
                        pv[x] = 1'b1;
                        pa[x] = ra[x];
                    end else begin
                        e_ovf = 1'b1;
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge CLK) begin
        if (m_ready) begin
            checkOutput("m_addr_valid", M_ADDR_VALID, e_mav);
            checkOutput("m_addr", M_ADDR, e_maddr);
            checkOutput("i_data_valid", I_DATA_VALID, busy && M_DATA_VALID && !own);
            checkOutput("d_data_valid", D_DATA_VALID, busy && M_DATA_VALID && own);
            checkOutput("i_access_fault", I_ACCESS_FAULT, e_fault[0]);
            checkOutput("d_access_fault", D_ACCESS_FAULT, e_fault[1]);
            checkOutput("overflow", OVERFLOW, e_ovf);
            checkOutput("pte_data", PTE_DATA, M_DATA);
        end
    end

    logic [63:0] issued[$];
    logic [63:0] expq[$];

    always @(negedge CLK) begin
        if (M_ADDR_VALID === 1'b1) issued.push_back(M_ADDR);
    end

    task automatic applyStimulus(input logic iv, input logic [63:0] ia, input logic dv,
                                 input logic [63:0] da, input logic mv, input logic [63:0] md);
        @(posedge CLK);
        #1;
        RST          = 1'b0;
        I_ADDR_VALID = iv;
        I_ADDR       = ia;
        D_ADDR_VALID = dv;
        D_ADDR       = da;
        M_DATA_VALID = mv;
        M_DATA       = md;
        @(negedge CLK);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic resetCycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            RST          = 1'b1;
            I_ADDR_VALID = 1'b0;
            I_ADDR       = '0;
            D_ADDR_VALID = 1'b0;
            D_ADDR       = '0;
            M_DATA_VALID = 1'b0;
            M_DATA       = '0;
            @(negedge CLK);
        end
        issued.delete();
    endtask

    // Wait (bounded) for the next grant, return data after lat cycles, then apply follow-up pulses.
    task automatic serveNext(input int lat, input logic [63:0] data, input logic ri, input logic [63:0] ai,
                             input logic rd, input logic [63:0] ad);
        int n;
        n = 0;
        while (M_ADDR_VALID !== 1'b1 && n < 40) begin
            idleCycles(1);
            n++;
        end
        if (M_ADDR_VALID !== 1'b1) begin
            checkOutput("grant_wait", M_ADDR_VALID, 1'b1);
            return;
        end
        idleCycles(lat);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, data);
        applyStimulus(ri, ai, rd, ad, 1'b0, '0);
    endtask

    task automatic checkIssued(input string name);
        checkOutput({name, "_count"}, 64'(issued.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < issued.size()) checkOutput($sformatf("%s_%0d", name, i), issued[i], expq[i]);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST          = 1'b1;
        I_ADDR_VALID = 1'b0;
        I_ADDR       = '0;
        D_ADDR_VALID = 1'b0;
        D_ADDR       = '0;
        M_DATA_VALID = 1'b0;
        M_DATA       = '0;

        $display("[TB] reset and single ITLB request");
        resetCycles(2);
        checkOutput("rst_m_addr_valid", M_ADDR_VALID, 1'b0);
        checkOutput("rst_m_addr", M_ADDR, 64'h0);
        checkOutput("rst_overflow", OVERFLOW, 1'b0);
        applyStimulus(1'b1, 64'h8000_1000, 1'b0, '0, 1'b0, '0);
        checkOutput("single_c0_mav", M_ADDR_VALID, 1'b0);
        idleCycles(1);
        checkOutput("single_c1_mav", M_ADDR_VALID, 1'b0);
        idleCycles(1);
        checkOutput("single_c2_mav", M_ADDR_VALID, 1'b1);
        checkOutput("single_c2_maddr", M_ADDR, 64'h8000_1000);
        idleCycles(1);
        checkOutput("single_c3_mav", M_ADDR_VALID, 1'b0);
        checkOutput("single_c3_maddr", M_ADDR, 64'h8000_1000);
        idleCycles(2);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 64'h2000_00CF);
        checkOutput("single_c6_idv", I_DATA_VALID, 1'b1);
        checkOutput("single_c6_ddv", D_DATA_VALID, 1'b0);
        checkOutput("single_c6_pte", PTE_DATA, 64'h2000_00CF);
        idleCycles(1);
        checkOutput("single_c7_idv", I_DATA_VALID, 1'b0);

        $display("[TB] simultaneous requests and alternating pointer");
        resetCycles(1);
        applyStimulus(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, '0);
        serveNext(1, 64'hA1, 1'b0, '0, 1'b0, '0);
        serveNext(0, 64'hA2, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 64'h1100, 1'b0, '0, 1'b0, '0);
        serveNext(2, 64'hA3, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 64'h1200, 1'b1, 64'h2200, 1'b0, '0);
        serveNext(1, 64'hA4, 1'b0, '0, 1'b0, '0);
        serveNext(1, 64'hA5, 1'b0, '0, 1'b0, '0);
        idleCycles(5);
        expq = '{64'h1000, 64'h2000, 64'h1100, 64'h2200, 64'h1200};
        checkIssued("simul_order");

        $display("[TB] interleaved three-level walks");
        resetCycles(1);
        applyStimulus(1'b1, 64'hA000, 1'b1, 64'hB000, 1'b0, '0);
        serveNext(1, 64'hC0, 1'b1, 64'hA100, 1'b0, '0);
        serveNext(2, 64'hC1, 1'b0, '0, 1'b1, 64'hB100);
        serveNext(0, 64'hC2, 1'b1, 64'hA200, 1'b0, '0);
        serveNext(3, 64'hC3, 1'b0, '0, 1'b1, 64'hB200);
        serveNext(1, 64'hC4, 1'b0, '0, 1'b0, '0);
        serveNext(1, 64'hC5, 1'b0, '0, 1'b0, '0);
        idleCycles(5);
        expq = '{64'hA000, 64'hB000, 64'hA100, 64'hB100, 64'hA200, 64'hB200};
        checkIssued("walk_order");

        $display("[TB] overflow");
        resetCycles(1);
        applyStimulus(1'b0, '0, 1'b1, 64'h3000, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b1, 64'h4000, 1'b0, '0);
        idleCycles(1);
        checkOutput("ovf_set", OVERFLOW, 1'b1);
        serveNext(1, 64'hD0, 1'b0, '0, 1'b0, '0);
        idleCycles(6);
        expq = '{64'h3000};
        checkIssued("ovf_order");
        checkOutput("ovf_sticky", OVERFLOW, 1'b1);
        resetCycles(1);
        idleCycles(1);
        checkOutput("ovf_cleared", OVERFLOW, 1'b0);

        $display("[TB] watchdog timeout");
        resetCycles(1);
        applyStimulus(1'b0, '0, 1'b1, 64'h5000, 1'b0, '0);
        for (int k = 1; k <= 19; k++) begin
            idleCycles(1);
            if (k == 2) checkOutput("to_issue", M_ADDR_VALID, 1'b1);
            if (k == 17) checkOutput("to_fault_pre", D_ACCESS_FAULT, 1'b0);
            if (k == 18) checkOutput("to_fault", D_ACCESS_FAULT, 1'b1);
            if (k == 18) checkOutput("to_fault_i", I_ACCESS_FAULT, 1'b0);
            if (k == 19) checkOutput("to_fault_post", D_ACCESS_FAULT, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 64'hEE);
        checkOutput("idle_data_ddv", D_DATA_VALID, 1'b0);
        checkOutput("idle_data_idv", I_DATA_VALID, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 64'h6000, 1'b0, '0);
        idleCycles(16);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 64'h55);
        checkOutput("last_wait_ddv", D_DATA_VALID, 1'b1);
        idleCycles(1);
        checkOutput("last_wait_nofault", D_ACCESS_FAULT, 1'b0);
        idleCycles(3);

        $display("[TB] reset during WAIT");
        resetCycles(1);
        applyStimulus(1'b1, 64'h7000, 1'b0, '0, 1'b0, '0);
        idleCycles(3);
        resetCycles(1);
        idleCycles(1);
        checkOutput("midrst_mav", M_ADDR_VALID, 1'b0);
        checkOutput("midrst_maddr", M_ADDR, 64'h0);
        checkOutput("midrst_ifault", I_ACCESS_FAULT, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 64'h77);
        checkOutput("midrst_idv", I_DATA_VALID, 1'b0);
        checkOutput("midrst_ddv", D_DATA_VALID, 1'b0);
        idleCycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
